demux2_32b_pipe: RTL and testbench

//   Registered 1-to-2 demultiplexer for 32-bit words: the steering counterpart of mux2_32b.

---
 rtl/demux2_32b_pipe.sv | 197 +++++++++++++++++++
 tb/tb_demux2_32b_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux2_32b_pipe.sv
// -----------------------------------------------------------------------------
// demux2_32b_pipe
//
// Registered 1-to-2 demultiplexer for WIDTH-bit words. One word per cycle is
// accepted on a valid/ready input and steered to output A (in_sel=0) or
// output B (in_sel=1). Each output owns a one-entry holding register, so a
// stalled consumer on one side never blocks traffic to the other side.
//
// Handshake semantics (all three interfaces):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   valid never depends on ready. Once x_valid is 1 the word on x_data is
//   held stable until it is transferred. in_ready is combinational from
//   rst, in_sel, the selected output's state and that output's ready; it
//   never looks at in_valid.
//
// Optional feature: define DEMUX2_CNT_EN to build saturating per-output
// delivery counters (cnt_a, cnt_b). Without it both ports are tied to 0 and
// no counter flops exist.
//
// Parameters:
//   WIDTH  data width in bits
//   CNT_W  width of the delivery counters
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active-high
//   in_valid  in   input word present
//   in_ready  out  block accepts the input word this cycle
//   in_sel    in   destination: 0 = A, 1 = B
//   in_data   in   input word
//   a_valid   out  output A holding register full (equals A's FSM state)
//   a_ready   in   consumer A takes the word this cycle
//   a_data    out  output A word
//   b_valid   out  output B holding register full (equals B's FSM state)
//   b_ready   in   consumer B takes the word this cycle
//   b_data    out  output B word
//   cnt_a     out  words delivered on A (DEMUX2_CNT_EN only, else 0)
//   cnt_b     out  words delivered on B (DEMUX2_CNT_EN only, else 0)
// -----------------------------------------------------------------------------
module demux2_32b_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  // Per-output holding register state. The state is exported directly as
  // a_valid / b_valid, which keeps the FSMs observable at the ports.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

  slot_state_t a_state, a_state_nxt;
  slot_state_t b_state, b_state_nxt;

  logic accept;
  logic a_load, b_load;
  logic a_drain, b_drain;

  // ---------------------------------------------------------------------------
  // Input side
  // ---------------------------------------------------------------------------
  // The selected slot can take a word if it is empty, or if it is full and
  // its consumer empties it on this same edge (pass-through reload).
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (in_sel) begin
        in_ready = (b_state == ST_EMPTY) || b_ready;
      end else begin
        in_ready = (a_state == ST_EMPTY) || a_ready;
      end
    end
  end

  assign accept  = in_valid && in_ready;
  assign a_load  = accept && !in_sel;
  assign b_load  = accept &&  in_sel;

  assign a_valid = (a_state == ST_FULL);
  assign b_valid = (b_state == ST_FULL);

  assign a_drain = a_valid && a_ready;
  assign b_drain = b_valid && b_ready;

  // ---------------------------------------------------------------------------
  // Output A FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    a_state_nxt = a_state;
    case (a_state)
      ST_EMPTY: begin
        if (a_load) begin
          a_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        // A load while full is only possible together with a drain, so the
        // slot stays FULL and simply reloads.
        if (a_drain && !a_load) begin
          a_state_nxt = ST_EMPTY;
        end
      end
      default: a_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_state <= ST_EMPTY;
      a_data  <= '0;
    end else begin
      a_state <= a_state_nxt;
      // Data moves only on a load; an empty slot keeps the last word.
      if (a_load) begin
        a_data <= in_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output B FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    b_state_nxt = b_state;
    case (b_state)
      ST_EMPTY: begin
        if (b_load) begin
          b_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (b_drain && !b_load) begin
          b_state_nxt = ST_EMPTY;
        end
      end
      default: b_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_state <= ST_EMPTY;
      b_data  <= '0;
    end else begin
      b_state <= b_state_nxt;
      if (b_load) begin
        b_data <= in_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Delivery counters
  // ---------------------------------------------------------------------------
`ifdef DEMUX2_CNT_EN
  logic [CNT_W-1:0] cnt_a_q;
  logic [CNT_W-1:0] cnt_b_q;

  // Saturate at all-ones rather than wrapping so a long run never reads
  // back as a small count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (a_drain && (cnt_a_q != {CNT_W{1'b1}})) begin
        cnt_a_q <= cnt_a_q + 1'b1;
      end
      if (b_drain && (cnt_b_q != {CNT_W{1'b1}})) begin
        cnt_b_q <= cnt_b_q + 1'b1;
      end
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`else
  assign cnt_a = '0;
  assign cnt_b = '0;
`endif

endmodule

// File: tb/tb_demux2_32b_pipe.sv
// -----------------------------------------------------------------------------
// tb_demux2_32b_pipe
//
// Directed bench for demux2_32b_pipe. A queue-per-output model predicts the
// outputs every cycle; directed sequences add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_demux2_32b_pipe;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  always #5 clk = ~clk;

  demux2_32b_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int v);
`ifdef DEMUX2_CNT_EN
    return 32'(v);
`else
    return 32'd0 + 32'(v - v);
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard: each output is a queue of words accepted but not yet taken
  // by its consumer (at most one deep). Delivered words are logged in order.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] exp_q_a[$];
  logic [WIDTH-1:0] exp_q_b[$];
  logic [WIDTH-1:0] dlv_a[$];
  logic [WIDTH-1:0] dlv_b[$];
  logic [WIDTH-1:0] last_a, last_b;
  int               n_a, n_b;
  logic             exp_rdy;
  logic             started = 1'b0;

  initial begin
    last_a = '0;
    last_b = '0;
    n_a = 0;
    n_b = 0;
  end

  always @(negedge clk) begin
    if (started) begin
      if (rst) begin
        exp_rdy = 1'b0;
      end else if (in_sel) begin
        exp_rdy = (exp_q_b.size() == 0) || b_ready;
      end else begin
        exp_rdy = (exp_q_a.size() == 0) || a_ready;
      end
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("a_valid", 32'(a_valid), (exp_q_a.size() != 0) ? 32'd1 : 32'd0);
      chk("a_data", a_data, (exp_q_a.size() != 0) ? exp_q_a[0] : last_a);
      chk("b_valid", 32'(b_valid), (exp_q_b.size() != 0) ? 32'd1 : 32'd0);
      chk("b_data", b_data, (exp_q_b.size() != 0) ? exp_q_b[0] : last_b);
      chk("cnt_a", 32'(cnt_a), cnt_exp(n_a));
      chk("cnt_b", 32'(cnt_b), cnt_exp(n_b));

      // Advance the model to what the next edge must produce.
      if (rst) begin
        exp_q_a.delete();
        exp_q_b.delete();
        last_a = '0;
        last_b = '0;
        n_a = 0;
        n_b = 0;
      end else begin
        if (exp_q_a.size() != 0 && a_ready) begin
          last_a = exp_q_a.pop_front();
          dlv_a.push_back(last_a);
          if (n_a < CNT_MAX) n_a++;
        end
        if (exp_q_b.size() != 0 && b_ready) begin
          last_b = exp_q_b.pop_front();
          dlv_b.push_back(last_b);
          if (n_b < CNT_MAX) n_b++;
        end
        if (in_valid && exp_rdy) begin
          if (in_sel) exp_q_b.push_back(in_data);
          else        exp_q_a.push_back(in_data);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic send(input logic sel, input logic [WIDTH-1:0] d, output int waited);
    bit done;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    waited   = 0;
    done     = 1'b0;
    while (!done && waited < 20) begin
      @(negedge clk);
      waited++;
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequences
  // ---------------------------------------------------------------------------
  initial begin
    int w;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    a_ready  = 1'b1;
    b_ready  = 1'b1;

    // T1: reset held two cycles with a word offered
    @(posedge clk);
    #1;
    started = 1'b1;
    @(negedge clk);
    chk("t1_in_ready", 32'(in_ready), 32'd0);
    chk("t1_a_valid", 32'(a_valid), 32'd0);
    chk("t1_b_valid", 32'(b_valid), 32'd0);
    chk("t1_a_data", a_data, 32'd0);
    chk("t1_b_data", b_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    idle(1);

    // T2: basic routing, consumers always ready
    send(1'b0, 32'h0000_00A1, w);
    chk("t2_a_wait", 32'(w), 32'd1);
    chk("t2_a_valid", 32'(a_valid), 32'd1);
    chk("t2_a_data", a_data, 32'h0000_00A1);
    send(1'b1, 32'h0000_00B2, w);
    chk("t2_b_wait", 32'(w), 32'd1);
    chk("t2_b_data", b_data, 32'h0000_00B2);
    chk("t2_a_drained", 32'(a_valid), 32'd0);
    idle(2);

    // T3: back-pressure on B
    b_ready = 1'b0;
    send(1'b1, 32'h11, w);
    in_valid = 1'b1;
    in_sel   = 1'b1;
    in_data  = 32'h22;
    repeat (2) begin
      @(negedge clk);
      chk("t3_blocked", 32'(in_ready), 32'd0);
      chk("t3_b_hold", b_data, 32'h11);
      @(posedge clk);
      #1;
    end
    send(1'b0, 32'h33, w);
    chk("t3_a_data", a_data, 32'h33);
    chk("t3_a_valid", 32'(a_valid), 32'd1);
    b_ready = 1'b1;
    send(1'b1, 32'h22, w);
    idle(3);
    chk("t3_b_count", 32'(dlv_b.size()), 32'd3);
    if (dlv_b.size() == 3) begin
      chk("t3_b_first", dlv_b[1], 32'h11);
      chk("t3_b_second", dlv_b[2], 32'h22);
    end
    chk("t3_a_count", 32'(dlv_a.size()), 32'd2);
    if (dlv_a.size() == 2) chk("t3_a_word", dlv_a[1], 32'h33);

    // T4: same-cycle drain and reload on B
    b_ready = 1'b0;
    send(1'b1, 32'h44, w);
    b_ready = 1'b1;
    send(1'b1, 32'h55, w);
    chk("t4_pass_ready", 32'(w), 32'd1);
    chk("t4_b_data", b_data, 32'h55);
    chk("t4_b_valid", 32'(b_valid), 32'd1);
    idle(2);
    chk("t4_b_count", 32'(dlv_b.size()), 32'd5);
    if (dlv_b.size() == 5) begin
      chk("t4_b_44", dlv_b[3], 32'h44);
      chk("t4_b_55", dlv_b[4], 32'h55);
    end
    chk("t4_cnt_a", 32'(cnt_a), cnt_exp(2));
    chk("t4_cnt_b", 32'(cnt_b), cnt_exp(5));

    // T5: reset while both slots hold words
    a_ready = 1'b0;
    b_ready = 1'b0;
    send(1'b0, 32'h66, w);
    send(1'b1, 32'h77, w);
    chk("t5_a_full", 32'(a_valid), 32'd1);
    chk("t5_b_full", 32'(b_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_a_valid", 32'(a_valid), 32'd0);
    chk("t5_b_valid", 32'(b_valid), 32'd0);
    a_ready = 1'b1;
    b_ready = 1'b1;
    idle(3);
    chk("t5_a_none", 32'(dlv_a.size()), 32'd2);
    chk("t5_b_none", 32'(dlv_b.size()), 32'd5);
    chk("t5_cnt_a", 32'(cnt_a), 32'd0);

    // T6: counters, 20 words to A and 3 to B
    for (int i = 0; i < 20; i++) send(1'b0, 32'h1000 + 32'(i), w);
    for (int i = 0; i < 3; i++) send(1'b1, 32'h2000 + 32'(i), w);
    idle(3);
    chk("t6_cnt_a", 32'(cnt_a), cnt_exp(15));
    chk("t6_cnt_b", 32'(cnt_b), cnt_exp(3));
    chk("t6_a_count", 32'(dlv_a.size()), 32'd22);
    chk("t6_a_last", a_data, 32'h1013);
    chk("t6_b_last", b_data, 32'h2002);

    started = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
